// File: rtl/player_input.sv
// Tug-of-war button conditioner: synchronises and debounces both player buttons
// and emits one-cycle L/R move pulses plus debounced held levels.

// State | meaning
// ------+------------------------------------------------------------
// IDLE  | button released and stable
// PWAIT | raw press seen, counting stable pressed samples
// HELD  | press accepted, waiting for release
// RWAIT | raw release seen, counting stable released samples
module player_input_chan #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic enable,
    output logic pulse,
    output logic held
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PWAIT = 2'd1;
    localparam logic [1:0] ST_HELD  = 2'd2;
    localparam logic [1:0] ST_RWAIT = 2'd3;

    logic          s1;
    logic          s2;
    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          fire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        fire      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (s2) begin
                    state_nxt = ST_PWAIT;
                    cnt_nxt   = '0;
                end
            end
            ST_PWAIT: begin
                if (!s2) begin
                    state_nxt = ST_IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_HELD;
                    fire      = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_HELD: begin
                if (!s2) begin
                    state_nxt = ST_RWAIT;
                    cnt_nxt   = '0;
                end
            end
            ST_RWAIT: begin
                if (s2) begin
                    state_nxt = ST_HELD;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // The FSM runs regardless of enable so a press completed while disabled is consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            pulse <= 1'b0;
            held  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pulse <= fire & enable;
            held  <= (state_nxt == ST_HELD) || (state_nxt == ST_RWAIT);
        end
    end

endmodule

module player_input #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_l,
    input  logic raw_r,
    input  logic enable,
    output logic L,
    output logic R,
    output logic held_l,
    output logic held_r
);

    // No arbitration between channels; downstream treats L&R as no move.
    player_input_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan_l (
        .clk    (clk),
        .reset  (reset),
        .raw    (raw_l),
        .enable (enable),
        .pulse  (L),
        .held   (held_l)
    );

    player_input_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan_r (
        .clk    (clk),
        .reset  (reset),
        .raw    (raw_r),
        .enable (enable),
        .pulse  (R),
        .held   (held_r)
    );

endmodule

// File: tb/tb_player_input.sv
// Directed bench for player_input with DEBOUNCE_CYCLES=4; expected values are
// hand-derived from the press/release latency rules (pulse after edge n+D+2).
module tb_player_input;

    localparam int D = 4;

    logic clk = 1'b0;
    logic reset;
    logic raw_l;
    logic raw_r;
    logic enable;
    logic l_pulse;
    logic r_pulse;
    logic held_l;
    logic held_r;

    int n_vec  = 0;
    int n_fail = 0;

    player_input #(.DEBOUNCE_CYCLES(D)) dut (
        .clk    (clk),
        .reset  (reset),
        .raw_l  (raw_l),
        .raw_r  (raw_r),
        .enable (enable),
        .L      (l_pulse),
        .R      (r_pulse),
        .held_l (held_l),
        .held_r (held_r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, want %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step through one full debounced press on the left channel, checking each cycle.
    task automatic press_l(input string tag, input logic exp_pulse);
        raw_l = 1'b1;
        for (int i = 0; i < D + 2; i++) begin
            step();
            chk({tag, "_pre"}, l_pulse, 1'b0);
        end
        step();
        chk({tag, "_pulse"}, l_pulse, exp_pulse);
        chk({tag, "_held"}, held_l, 1'b1);
        step();
        chk({tag, "_after"}, l_pulse, 1'b0);
    endtask

    task automatic release_l(input string tag);
        raw_l = 1'b0;
        for (int i = 0; i < D + 2; i++) begin
            step();
            chk({tag, "_still_held"}, held_l, 1'b1);
        end
        step();
        chk({tag, "_released"}, held_l, 1'b0);
    endtask

    initial begin
        reset  = 1'b1;
        raw_l  = 1'b0;
        raw_r  = 1'b0;
        enable = 1'b1;
        #1;
        chk("rst_L", l_pulse, 1'b0);
        chk("rst_R", r_pulse, 1'b0);
        chk("rst_held_l", held_l, 1'b0);
        chk("rst_held_r", held_r, 1'b0);
        step();
        step();
        reset = 1'b0;
        step();

        // Clean press then release.
        press_l("clean", 1'b1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("clean_hold_nopulse", l_pulse, 1'b0);
        end
        release_l("clean_rel");

        // Asynchronous reset in the very cycle L is high.
        raw_l = 1'b1;
        for (int i = 0; i < D + 3; i++) step();
        chk("rst_pre_L", l_pulse, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async_L", l_pulse, 1'b0);
        chk("rst_async_held", held_l, 1'b0);
        step();
        #2;
        reset = 1'b0;
        press_l("post_rst", 1'b1);
        release_l("post_rst_rel");

        // Bounce on right: 3 high, 1 low, then held high.
        raw_r = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bounce_R_a", r_pulse, 1'b0);
            chk("bounce_held_r_a", held_r, 1'b0);
        end
        raw_r = 1'b0;
        step();
        chk("bounce_R_b", r_pulse, 1'b0);
        raw_r = 1'b1;
        for (int i = 0; i < D + 2; i++) begin
            step();
            chk("bounce_R_c", r_pulse, 1'b0);
            chk("bounce_held_r_c", held_r, 1'b0);
        end
        step();
        chk("bounce_R_fire", r_pulse, 1'b1);
        chk("bounce_held_r_fire", held_r, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("bounce_R_once", r_pulse, 1'b0);
        end
        raw_r = 1'b0;
        for (int i = 0; i < D + 3; i++) step();
        chk("bounce_held_r_rel", held_r, 1'b0);

        // Simultaneous press.
        raw_l = 1'b1;
        raw_r = 1'b1;
        for (int i = 0; i < D + 2; i++) begin
            step();
            chk("sim_L_pre", l_pulse, 1'b0);
            chk("sim_R_pre", r_pulse, 1'b0);
        end
        step();
        chk("sim_L", l_pulse, 1'b1);
        chk("sim_R", r_pulse, 1'b1);
        step();
        chk("sim_L_after", l_pulse, 1'b0);
        chk("sim_R_after", r_pulse, 1'b0);
        raw_r = 1'b0;
        for (int i = 0; i < D + 3; i++) step();
        chk("sim_held_r_rel", held_r, 1'b0);
        release_l("sim_rel");

        // Press completes while disabled: consumed, never fires.
        enable = 1'b0;
        press_l("dis", 1'b0);
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("dis_enable_nopulse", l_pulse, 1'b0);
            chk("dis_enable_held", held_l, 1'b1);
        end
        release_l("dis_rel");
        press_l("dis_repress", 1'b1);

        // Release bounce from HELD: 2 low samples then high again.
        raw_l = 1'b0;
        step();
        step();
        raw_l = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("relb_held", held_l, 1'b1);
            chk("relb_nopulse", l_pulse, 1'b0);
        end
        release_l("relb_rel");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, want finish");
        $fatal(1);
    end

endmodule
